alu181_pipe: RTL and testbench

ALU181_PIPE -- requirements
Module: alu181_pipe

---
 rtl/alu181_pipe.sv | 123 ++++++++++++
 tb/tb_alu181_pipe.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu181_pipe.sv
// alu181_pipe: two-stage valid/ready pipelined 74181-style ALU.
//   Stage 1 registers the operation; stage 2 evaluates it and registers F and flags.
//   Optional feature: define ALU181_OVF_EN to add the signed-overflow output V.
module alu181_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             M,
  input  logic             Cn,
  input  logic [3:0]       Sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] F,
  output logic             Cout,
  output logic             Zero,
  output logic             AeqB,
`ifdef ALU181_OVF_EN
  output logic             V,
`endif
  output logic             out_valid,
  input  logic             out_ready
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             m;
    logic             cn;
    logic [3:0]       sel;
  } op_t;

  // vld_pipe[1]: stage 1 holds an operation; vld_pipe[2]: stage 2 holds a result
  logic [2:1]       vld_pipe;
  op_t              s1;
  logic             accept, s1_move;
  logic [WIDTH-1:0] p, q, lf, f_nx;
  logic [WIDTH:0]   sum;
  logic             cout_nx, v_nx;

  // stage 1 may advance when stage 2 is empty or its result is being taken
  assign s1_move   = vld_pipe[1] && (!vld_pipe[2] || out_ready);
  assign in_ready  = !vld_pipe[1] || !vld_pipe[2] || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = vld_pipe[2];

  // function decode: logic result and arithmetic addend pair for each Sel
  always_comb begin
    p  = '0;
    q  = '0;
    lf = '0;
    case (s1.sel)
      4'h0: begin lf = ~s1.a;             p = s1.a;           q = '0;             end
      4'h1: begin lf = ~(s1.a | s1.b);    p = s1.a | s1.b;    q = '0;             end
      4'h2: begin lf = ~s1.a & s1.b;      p = s1.a | ~s1.b;   q = '0;             end
      4'h3: begin lf = '0;                p = '1;             q = '0;             end
      4'h4: begin lf = ~(s1.a & s1.b);    p = s1.a;           q = s1.a & ~s1.b;   end
      4'h5: begin lf = ~s1.b;             p = s1.a | s1.b;    q = s1.a & ~s1.b;   end
      4'h6: begin lf = s1.a ^ s1.b;       p = s1.a;           q = ~s1.b;          end
      4'h7: begin lf = s1.a & ~s1.b;      p = s1.a & ~s1.b;   q = '1;             end
      4'h8: begin lf = ~s1.a | s1.b;      p = s1.a;           q = s1.a & s1.b;    end
      4'h9: begin lf = ~(s1.a ^ s1.b);    p = s1.a;           q = s1.b;           end
      4'ha: begin lf = s1.b;              p = s1.a | ~s1.b;   q = s1.a & s1.b;    end
      4'hb: begin lf = s1.a & s1.b;       p = s1.a & s1.b;    q = '1;             end
      4'hc: begin lf = '1;                p = s1.a;           q = s1.a;           end
      4'hd: begin lf = s1.a | ~s1.b;      p = s1.a | s1.b;    q = s1.a;           end
      4'he: begin lf = s1.a | s1.b;       p = s1.a | ~s1.b;   q = s1.a;           end
      default: begin lf = s1.a;           p = s1.a;           q = '1;             end
    endcase
  end

  // arithmetic path and result mux; Cn only matters in arithmetic mode
  always_comb begin
    sum     = {1'b0, p} + {1'b0, q} + {{WIDTH{1'b0}}, s1.cn};
    f_nx    = s1.m ? lf : sum[WIDTH-1:0];
    cout_nx = !s1.m && sum[WIDTH];
    // carry into the MSB is recovered from the MSB sum bit
    v_nx    = !s1.m && ((p[WIDTH-1] ^ q[WIDTH-1] ^ sum[WIDTH-1]) ^ sum[WIDTH]);
  end

  // pipeline registers: both stages can advance in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1       <= '0;
      F        <= '0;
      Cout     <= 1'b0;
      Zero     <= 1'b0;
      AeqB     <= 1'b0;
`ifdef ALU181_OVF_EN
      V        <= 1'b0;
`endif
    end else begin
      if (accept) begin
        s1          <= '{a: A, b: B, m: M, cn: Cn, sel: Sel};
        vld_pipe[1] <= 1'b1;
      end else if (s1_move) begin
        vld_pipe[1] <= 1'b0;
      end
      if (s1_move) begin
        vld_pipe[2] <= 1'b1;
        F           <= f_nx;
        Cout        <= cout_nx;
        Zero        <= (f_nx == '0);
        AeqB        <= (s1.a == s1.b);
`ifdef ALU181_OVF_EN
        V           <= v_nx;
`endif
      end else if (out_ready) begin
        vld_pipe[2] <= 1'b0;
      end
    end
  end

`ifndef ALU181_OVF_EN
  // overflow is only exported when the feature is enabled
  logic unused_v;
  assign unused_v = v_nx;
`endif

endmodule

// File: tb/tb_alu181_pipe.sv
// tb_alu181_pipe: randomized and directed checks of alu181_pipe against a
// behavioural model; WIDTH=8 main instance, WIDTH=16 instance for the wide case.
module tb_alu181_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b, f;
  logic       m, cn, in_valid, in_ready, cout, zero, aeqb, out_valid, out_ready;
  logic [3:0] sel;
  logic       v;
  logic [15:0] a16, b16, f16;
  logic        m16, cn16, iv16, ir16, cout16, zero16, aeqb16, ov16, or16;
  logic [3:0]  sel16;
  logic        v16;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    longint f;
    bit     cout;
    bit     zero;
    bit     aeqb;
    bit     v;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu181_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .M(m), .Cn(cn), .Sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .F(f), .Cout(cout), .Zero(zero), .AeqB(aeqb),
`ifdef ALU181_OVF_EN
    .V(v),
`endif
    .out_valid(out_valid), .out_ready(out_ready)
  );

  alu181_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .A(a16), .B(b16), .M(m16), .Cn(cn16), .Sel(sel16),
    .in_valid(iv16), .in_ready(ir16), .F(f16), .Cout(cout16), .Zero(zero16), .AeqB(aeqb16),
`ifdef ALU181_OVF_EN
    .V(v16),
`endif
    .out_valid(ov16), .out_ready(or16)
  );

`ifndef ALU181_OVF_EN
  assign v   = 1'b0;
  assign v16 = 1'b0;
`endif

  // reference: logic table and addend pairs evaluated with plain integers;
  // overflow is judged by whether the true signed sum fits in w bits
  function automatic exp_t model(input longint xa, xb, input bit xm, xcn, input int xsel, input int w);
    longint msk, hi, na, nb, p, q, s, lv, sp, sq, ss;
    exp_t   e;
    msk = (longint'(1) << w) - 1;
    hi  = longint'(1) << (w - 1);
    na  = ~xa & msk;
    nb  = ~xb & msk;
    p = 0; q = 0; lv = 0;
    case (xsel)
      0:  lv = na;            1:  lv = ~(xa | xb);   2:  lv = na & xb;      3:  lv = 0;
      4:  lv = ~(xa & xb);    5:  lv = nb;           6:  lv = xa ^ xb;      7:  lv = xa & nb;
      8:  lv = na | xb;       9:  lv = ~(xa ^ xb);   10: lv = xb;           11: lv = xa & xb;
      12: lv = msk;           13: lv = xa | nb;      14: lv = xa | xb;      default: lv = xa;
    endcase
    case (xsel)
      0:  begin p = xa;        q = 0;        end
      1:  begin p = xa | xb;   q = 0;        end
      2:  begin p = xa | nb;   q = 0;        end
      3:  begin p = msk;       q = 0;        end
      4:  begin p = xa;        q = xa & nb;  end
      5:  begin p = xa | xb;   q = xa & nb;  end
      6:  begin p = xa;        q = nb;       end
      7:  begin p = xa & nb;   q = msk;      end
      8:  begin p = xa;        q = xa & xb;  end
      9:  begin p = xa;        q = xb;       end
      10: begin p = xa | nb;   q = xa & xb;  end
      11: begin p = xa & xb;   q = msk;      end
      12: begin p = xa;        q = xa;       end
      13: begin p = xa | xb;   q = xa;       end
      14: begin p = xa | nb;   q = xa;       end
      default: begin p = xa;   q = msk;      end
    endcase
    s = p + q + longint'(xcn);
    if (xm) begin
      e.f = lv & msk; e.cout = 1'b0; e.v = 1'b0;
    end else begin
      e.f    = s & msk;
      e.cout = s[w];
      sp = (p >= hi) ? p - (msk + 1) : p;
      sq = (q >= hi) ? q - (msk + 1) : q;
      ss = sp + sq + longint'(xcn);
      e.v = (ss >= hi) || (ss < -hi);
    end
    e.zero = (e.f == 0);
    e.aeqb = (xa == xb);
    return e;
  endfunction

  task automatic rand_op();
    a   = 8'($urandom);
    b   = ($urandom_range(0, 9) == 0) ? a : 8'($urandom);
    m   = 1'($urandom);
    cn  = 1'($urandom);
    sel = 4'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; iv16 = 1'b0; or16 = 1'b1;
    a = 8'h12; b = 8'h34; m = 1'b0; cn = 1'b0; sel = 4'h9;
    a16 = '0; b16 = '0; m16 = 1'b0; cn16 = 1'b0; sel16 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, f, cout, zero, aeqb, v} !== 13'h0) begin
      n_err++; $display("FAIL reset_state got=%h want=0", {out_valid, f, cout, zero, aeqb, v});
    end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_no_output cyc=%0d got=%b want=0", i, out_valid); end
    end
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       m, cn;
    logic [3:0] sel;
    logic [7:0] f;
    logic       cout, zero, aeqb, v;
  } vec_t;

  task automatic test_vectors();
    vec_t tbl[8];
    tbl[0] = '{8'h85, 8'hAA, 1'b0, 1'b0, 4'h9, 8'h2F, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{8'h85, 8'hAA, 1'b0, 1'b1, 4'h6, 8'hDB, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{8'h85, 8'hAA, 1'b1, 1'b0, 4'hB, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{8'h85, 8'hAA, 1'b1, 1'b1, 4'hB, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{8'h85, 8'hAA, 1'b1, 1'b0, 4'h6, 8'h2F, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{8'h3C, 8'h3C, 1'b1, 1'b0, 4'h6, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{8'h3C, 8'h3C, 1'b1, 1'b0, 4'hC, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{8'hFF, 8'h01, 1'b0, 1'b0, 4'h9, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      a = tbl[i].a; b = tbl[i].b; m = tbl[i].m; cn = tbl[i].cn; sel = tbl[i].sel;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL vec%0d_early got=%b want=0", i, out_valid); end
      @(negedge clk);
      n_cmp++;
      if ({out_valid, f, cout, zero, aeqb} !== {1'b1, tbl[i].f, tbl[i].cout, tbl[i].zero, tbl[i].aeqb}) begin
        n_err++;
        $display("FAIL vec%0d_result got vld=%b F=%h C=%b Z=%b E=%b want vld=1 F=%h C=%b Z=%b E=%b",
                 i, out_valid, f, cout, zero, aeqb, tbl[i].f, tbl[i].cout, tbl[i].zero, tbl[i].aeqb);
      end
`ifdef ALU181_OVF_EN
      n_cmp++;
      if (v !== tbl[i].v) begin n_err++; $display("FAIL vec%0d_v got=%b want=%b", i, v, tbl[i].v); end
`endif
    end
  endtask

  task automatic test_stall();
    logic [7:0] oa[4], ob[4];
    logic       om[4], oc[4];
    logic [3:0] os[4];
    exp_t       e;
    int         idx = 0;
    int         got = 0;
    for (int i = 0; i < 4; i++) begin
      rand_op();
      oa[i] = a; ob[i] = b; om[i] = m; oc[i] = cn; os[i] = sel;
    end
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      @(posedge clk); #1;
      in_valid  = (idx < 4);
      if (idx < 4) begin a = oa[idx]; b = ob[idx]; m = om[idx]; cn = oc[idx]; sel = os[idx]; end
      out_ready = (cyc >= 3);
      @(negedge clk);
      if (cyc <= 2) begin
        n_cmp++;
        if (in_ready !== (cyc < 2)) begin n_err++; $display("FAIL stall_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, cyc < 2); end
      end
      if (out_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL stall_spurious cyc=%0d got=valid want=idle", cyc);
        end else if ({f, cout, zero, aeqb} !== {exp_q[0].f[7:0], exp_q[0].cout, exp_q[0].zero, exp_q[0].aeqb}) begin
          n_err++;
          $display("FAIL stall_result cyc=%0d got F=%h C=%b Z=%b E=%b want F=%h C=%b Z=%b E=%b", cyc,
                   f, cout, zero, aeqb, exp_q[0].f[7:0], exp_q[0].cout, exp_q[0].zero, exp_q[0].aeqb);
        end
        if (out_ready && exp_q.size() != 0) begin void'(exp_q.pop_front()); got++; end
      end
      if (in_valid && in_ready) begin
        e = model(longint'(a), longint'(b), m, cn, int'(sel), 8);
        exp_q.push_back(e);
        idx++;
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (got != 4) begin n_err++; $display("FAIL stall_count got=%0d want=4", got); end
    exp_q.delete();
  endtask

  task automatic test_random();
    exp_t e;
    for (int cyc = 0; cyc < 420; cyc++) begin
      @(posedge clk); #1;
      if (cyc < 400) begin
        rand_op();
        in_valid  = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 9) < 6);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (out_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL random_spurious cyc=%0d got=valid want=idle", cyc);
        end else begin
          if ({f, cout, zero, aeqb} !== {exp_q[0].f[7:0], exp_q[0].cout, exp_q[0].zero, exp_q[0].aeqb}) begin
            n_err++;
            $display("FAIL random_result cyc=%0d got F=%h C=%b Z=%b E=%b want F=%h C=%b Z=%b E=%b", cyc,
                     f, cout, zero, aeqb, exp_q[0].f[7:0], exp_q[0].cout, exp_q[0].zero, exp_q[0].aeqb);
          end
`ifdef ALU181_OVF_EN
          n_cmp++;
          if (v !== exp_q[0].v) begin n_err++; $display("FAIL random_v cyc=%0d got=%b want=%b", cyc, v, exp_q[0].v); end
`endif
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        e = model(longint'(a), longint'(b), m, cn, int'(sel), 8);
        exp_q.push_back(e);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL random_drain got=%0d pending want=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_midreset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      a = 8'h85; b = 8'hAA; m = 1'b0; cn = 1'b0; sel = 4'h9;
      in_valid = 1'b1; out_ready = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b10) begin n_err++; $display("FAIL midrst_full got vld/rdy=%b want=10", {out_valid, in_ready}); end
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, f, cout, zero, aeqb, in_ready} !== 13'h001) begin
      n_err++; $display("FAIL midrst_clear got vld=%b F=%h C=%b Z=%b E=%b rdy=%b want vld=0 F=00 C=0 Z=0 E=0 rdy=1",
                        out_valid, f, cout, zero, aeqb, in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_stale cyc=%0d got=%b want=0", i, out_valid); end
    end
  endtask

  task automatic test_w16();
    logic [15:0] ta[2], tb16[2];
    exp_t        e;
    ta[0] = 16'hFFFF; tb16[0] = 16'h0001;
    ta[1] = 16'h7FFF; tb16[1] = 16'h0001;
    for (int i = 0; i < 2; i++) begin
      e = model(longint'(ta[i]), longint'(tb16[i]), 1'b0, 1'b0, 9, 16);
      @(posedge clk); #1;
      a16 = ta[i]; b16 = tb16[i]; m16 = 1'b0; cn16 = 1'b0; sel16 = 4'h9; iv16 = 1'b1; or16 = 1'b1;
      @(posedge clk); #1;
      iv16 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if ({ov16, f16, cout16, zero16} !== {1'b1, e.f[15:0], e.cout, e.zero}) begin
        n_err++; $display("FAIL w16_op%0d got vld=%b F=%h C=%b Z=%b want vld=1 F=%h C=%b Z=%b",
                          i, ov16, f16, cout16, zero16, e.f[15:0], e.cout, e.zero);
      end
`ifdef ALU181_OVF_EN
      n_cmp++;
      if (v16 !== e.v) begin n_err++; $display("FAIL w16_v%0d got=%b want=%b", i, v16, e.v); end
`endif
    end
    // the wrap case must give exactly F=0000, Cout=1, Zero=1
    n_cmp++;
    e = model(64'hFFFF, 64'h1, 1'b0, 1'b0, 9, 16);
    if ({e.f[15:0], e.cout, e.zero} !== {16'h0000, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL w16_model got F=%h C=%b Z=%b want F=0000 C=1 Z=1", e.f[15:0], e.cout, e.zero);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout sim time exceeded");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_vectors();
    test_stall();
    test_random();
    test_midreset();
    test_w16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
